v_hier_qvec_monitor: RTL and testbench

Consumes the qvec[2:0] bus produced by the v_hier_sub stage and detects every change in its value. Each change is logged as a record {old value, new value, timestamp} into a small show-ahead FIFO. Records drain through a valid/ready handshake to downstream debug/trace logic. Changes that arrive while the FIFO is full are counted.

---
 rtl/v_hier_qvec_monitor.sv | 194 +++++++++++++++++++
 tb/tb_v_hier_qvec_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v_hier_qvec_monitor.sv
// ---------------------------------------------------------------------------
// v_hier_qvec_monitor
//
// Purpose:
//   Watches the qvec bus coming out of the v_hier_sub stage and logs every
//   change of its value. Each change becomes a record {old, new, timestamp}.
//   Records are held in a small show-ahead FIFO and drained through a
//   valid/ready handshake. Changes that arrive while the FIFO is full are
//   dropped, and a saturating counter keeps track of them.
//
// Ports:
//   clk        in   1               sole clock, rising edge
//   reset      in   1               asynchronous, active-high, clears all state
//   qvec       in   WIDTH           monitored bus, synchronous to clk
//   rec_valid  out  1               head record available (level != 0)
//   rec_ready  in   1               consumer accepts the head record
//   rec_old    out  WIDTH           value before the change
//   rec_new    out  WIDTH           value after the change
//   rec_ts     out  TS_W            timestamp of the detection cycle
//   level      out  clog2(DEPTH)+1  FIFO occupancy
//   ovf_cnt    out  CNT_W           dropped-record count, saturating
//
// Notes:
//   - Every output is taken directly from registers. qvec reaches only the
//     sampling flops, and rec_ready only affects next-state logic, so
//     rec_valid cannot combinationally depend on rec_ready.
//   - The FIFO storage is cleared by reset so that rec_old/rec_new/rec_ts
//     read as zero while the FIFO is empty after reset.
// ---------------------------------------------------------------------------
module v_hier_qvec_monitor #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         qvec,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [WIDTH-1:0]         rec_old,
    output logic [WIDTH-1:0]         rec_new,
    output logic [TS_W-1:0]          rec_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1;
    logic             r_s1_ok;
    logic [WIDTH-1:0] r_s2;
    logic             r_s2_ok;
    logic [TS_W-1:0]  r_ts;

    logic [WIDTH-1:0] r_mem_old [DEPTH];
    logic [WIDTH-1:0] r_mem_new [DEPTH];
    logic [TS_W-1:0]  r_mem_ts  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_ovf_cnt;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    logic             w_evt;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [LVL_W-1:0] w_level_nxt;
    logic [CNT_W-1:0] w_ovf_nxt;

    // Two-stage sampler with "ok" flags so the first two edges after reset
    // can never look like a change (the flops start at zero, qvec may not).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= {WIDTH{1'b0}};
            r_s1_ok <= 1'b0;
            r_s2    <= {WIDTH{1'b0}};
            r_s2_ok <= 1'b0;
        end else begin
            r_s1    <= qvec;
            r_s1_ok <= 1'b1;
            r_s2    <= r_s1;
            r_s2_ok <= r_s1_ok;
        end
    end

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= {TS_W{1'b0}};
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Change detection and FIFO control. A push into a full FIFO is still
    // accepted when the head leaves in the same cycle.
    always_comb begin
        w_evt   = r_s1_ok & r_s2_ok & (r_s1 != r_s2);
        w_full  = (r_level == LVL_FULL);
        w_valid = (r_level != LVL_ZERO);
        w_pop   = w_valid & rec_ready;
        w_push  = w_evt & (~w_full | w_pop);
        w_drop  = w_evt & w_full & ~w_pop;
    end

    // Next occupancy: level + push - pop.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Next overflow count: saturates instead of wrapping.
    always_comb begin
        w_ovf_nxt = r_ovf_cnt;
        if (w_drop && (r_ovf_cnt != CNT_MAX)) begin
            w_ovf_nxt = r_ovf_cnt + CNT_ONE;
        end else begin
            w_ovf_nxt = r_ovf_cnt;
        end
    end

    // FIFO storage: the record written is the one seen during the detection
    // cycle, i.e. {s2, s1, current ts}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_old[i] <= {WIDTH{1'b0}};
                r_mem_new[i] <= {WIDTH{1'b0}};
                r_mem_ts[i]  <= {TS_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem_old[r_wr_ptr] <= r_s2;
                r_mem_new[r_wr_ptr] <= r_s1;
                r_mem_ts[r_wr_ptr]  <= r_ts;
            end
        end
    end

    // Pointers (modulo DEPTH via natural wrap, DEPTH is a power of 2),
    // occupancy and overflow counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_level   <= LVL_ZERO;
            r_ovf_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level   <= w_level_nxt;
            r_ovf_cnt <= w_ovf_nxt;
        end
    end

    // Show-ahead outputs: the head entry is always visible. After the last
    // pop these hold stale contents, which is harmless since rec_valid is 0.
    always_comb begin
        rec_valid = w_valid;
        rec_old   = r_mem_old[r_rd_ptr];
        rec_new   = r_mem_new[r_rd_ptr];
        rec_ts    = r_mem_ts[r_rd_ptr];
        level     = r_level;
        ovf_cnt   = r_ovf_cnt;
    end

endmodule

// File: tb/tb_v_hier_qvec_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for v_hier_qvec_monitor.
// A queue-based model counts edges since reset, remembers the last two
// samples of qvec, and decides per edge what the FIFO contents and the
// overflow count must be. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_v_hier_qvec_monitor;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int TS_W  = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] qvec;
    logic             rec_valid;
    logic             rec_ready;
    logic [WIDTH-1:0] rec_old;
    logic [WIDTH-1:0] rec_new;
    logic [TS_W-1:0]  rec_ts;
    logic [2:0]       level;
    logic [CNT_W-1:0] ovf_cnt;

    always #5 clk = ~clk;

    v_hier_qvec_monitor #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .qvec      (qvec),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_old   (rec_old),
        .rec_new   (rec_new),
        .rec_ts    (rec_ts),
        .level     (level),
        .ovf_cnt   (ovf_cnt)
    );

    typedef struct packed {
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] n;
        logic [TS_W-1:0]  t;
    } rec_t;

    rec_t             mq[$];
    int               m_edges;
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_prev;
    int               m_ovf;
    int               checks = 0;
    int               errors = 0;
    logic [TS_W-1:0]  exp_ts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_edges = 0;
        m_last  = '0;
        m_prev  = '0;
        m_ovf   = 0;
    endtask

    // One rising edge: a change seen between the samples of edges c-1 and c
    // (c >= 2) is logged at edge c+1 with timestamp c.
    task automatic model_edge();
        bit   pop;
        bit   evt;
        int   sz;
        rec_t r;
        sz  = mq.size();
        pop = (sz != 0) && rec_ready;
        evt = (m_edges >= 2) && (m_last != m_prev);
        if (pop) void'(mq.pop_front());
        if (evt) begin
            if (sz < DEPTH || pop) begin
                r.o = m_prev;
                r.n = m_last;
                r.t = m_edges[TS_W-1:0];
                mq.push_back(r);
            end else if (m_ovf < (1 << CNT_W) - 1) begin
                m_ovf++;
            end
        end
        m_prev = m_last;
        m_last = qvec;
        m_edges++;
    endtask

    task automatic compare();
        chk("rec_valid", {31'd0, rec_valid}, {31'd0, mq.size() != 0});
        chk("level", {29'd0, level}, mq.size());
        chk("ovf_cnt", {24'd0, ovf_cnt}, m_ovf);
        if (mq.size() != 0) begin
            chk("rec_old", {29'd0, rec_old}, {29'd0, mq[0].o});
            chk("rec_new", {29'd0, rec_new}, {29'd0, mq[0].n});
            chk("rec_ts", {24'd0, rec_ts}, {24'd0, mq[0].t});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Reset pulse placed between edges (called at edge+1).
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", {31'd0, rec_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        chk("rst_old", {29'd0, rec_old}, 32'd0);
        chk("rst_ts", {24'd0, rec_ts}, 32'd0);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset     = 1'b1;
        qvec      = 3'b101;
        rec_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_valid", {31'd0, rec_valid}, 32'd0);
        chk("init_level", {29'd0, level}, 32'd0);
        chk("init_ovf", {24'd0, ovf_cnt}, 32'd0);
        chk("init_new", {29'd0, rec_new}, 32'd0);
        reset = 1'b0;
        model_reset();

        // 1: nonzero qvec held after release is not a change
        repeat (10) step();
        chk("t1_level", {29'd0, level}, 32'd0);
        chk("t1_valid", {31'd0, rec_valid}, 32'd0);
        chk("t1_ovf", {24'd0, ovf_cnt}, 32'd0);

        // 2: single change 000 -> 011, ready held high
        rec_ready = 1'b1;
        qvec      = 3'b000;
        repeat (5) step();
        qvec = 3'b011;
        step();
        exp_ts = m_edges[TS_W-1:0];
        chk("t2_before", {31'd0, rec_valid}, 32'd0);
        step();
        chk("t2_valid", {31'd0, rec_valid}, 32'd1);
        chk("t2_old", {29'd0, rec_old}, 32'd0);
        chk("t2_new", {29'd0, rec_new}, 32'd3);
        chk("t2_ts", {24'd0, rec_ts}, {24'd0, exp_ts});
        step();
        chk("t2_after", {31'd0, rec_valid}, 32'd0);

        // 3: six back-to-back changes into a 4-deep FIFO
        qvec = 3'd0;
        repeat (5) step();
        rec_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            qvec = 3'(v);
            step();
        end
        repeat (3) step();
        chk("t3_level", {29'd0, level}, 32'd4);
        chk("t3_ovf", {24'd0, ovf_cnt}, 32'd2);
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_old", {29'd0, rec_old}, i);
            chk("t3_drain_new", {29'd0, rec_new}, i + 1);
            step();
        end
        chk("t3_empty", {29'd0, level}, 32'd0);

        // 4: full FIFO, push and pop in the same cycle
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            qvec = (qvec == 3'd7) ? 3'd6 : 3'd7;
            step();
        end
        repeat (2) step();
        chk("t4_full", {29'd0, level}, 32'd4);
        qvec = 3'd7;
        step();
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        chk("t4_level", {29'd0, level}, 32'd4);
        chk("t4_ovf", {24'd0, ovf_cnt}, 32'd2);
        rec_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t4_tail_old", {29'd0, rec_old}, 32'd6);
        chk("t4_tail_new", {29'd0, rec_new}, 32'd7);
        step();

        // 5: overflow counter saturates
        rec_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            qvec = (qvec == 3'd7) ? 3'd6 : 3'd7;
            step();
        end
        repeat (2) step();
        chk("t5_sat", {24'd0, ovf_cnt}, 32'd255);
        for (int i = 0; i < 10; i++) begin
            qvec = (qvec == 3'd7) ? 3'd6 : 3'd7;
            step();
        end
        repeat (2) step();
        chk("t5_hold", {24'd0, ovf_cnt}, 32'd255);

        // 6: asynchronous reset at level 3
        repeat (3) step();
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        chk("t6_level3", {29'd0, level}, 32'd3);
        mid_reset();
        qvec = 3'd5;
        step();
        step();
        chk("t6_no_rec", {29'd0, level}, 32'd0);
        qvec = 3'd2;
        step();
        step();
        chk("t6_valid", {31'd0, rec_valid}, 32'd1);
        chk("t6_ts", {24'd0, rec_ts}, 32'd3);
        chk("t6_old", {29'd0, rec_old}, 32'd5);
        chk("t6_new", {29'd0, rec_new}, 32'd2);

        // Random traffic with varying consumer pressure and rare resets
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) != 0) qvec = 3'($urandom_range(0, 7));
                rec_ready = ($urandom_range(0, 99) < rdy_pct);
                if ($urandom_range(0, 399) == 0) mid_reset();
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
